lm75_i2c_reader: RTL and testbench

- I2C initiator that reads the 2-byte temperature register of an LM75-class sensor.
- Presents the raw 16-bit word (MSB integer with sign in bit 15, bit 7 = 0.5 °C) to the downstream BCD decoder.
- Runs single-master, 7-bit addressing, pointer register left at power-up default 0 (temperature).
- Sits between the board I2C pins and the display decode path; triggered by a periodic poll pulse.

---
 rtl/lm75_i2c_reader.sv | 137 +++++++++++++
 tb/tb_lm75_i2c_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lm75_i2c_reader.sv
// I2C initiator that fetches the 2-byte temperature word from an LM75-class sensor.
// Each bit slot is four quarters; SCL is low in Q0-Q1 and high in Q2-Q3.
module lm75_i2c_reader #(
    parameter int         QUARTER_CLKS = 125,
    parameter logic [6:0] DEV_ADDR     = 7'h48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_oe,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy,
    output logic        nack_err
);

    localparam int          QW        = (QUARTER_CLKS > 2) ? $clog2(QUARTER_CLKS) : 1;
    localparam logic [QW-1:0] QLAST   = QW'(QUARTER_CLKS - 1);
    localparam logic [QW-1:0] QONE    = QW'(1);
    localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, RD_MSB, ACK_MSB, RD_LSB, NACK_LSB, STOP, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [QW-1:0]   qcnt;
    logic [1:0]      q;
    logic [2:0]      bcnt;
    logic [15:0]     sreg;
    logic            ack_samp;
    logic            qend, slot_end, sample, active, multi, last_bit;

    function automatic logic addr_bit(input logic [2:0] idx);
        addr_bit = ADDR_BYTE[3'd7 - idx];
    endfunction

    assign qend     = (qcnt == QLAST);
    assign slot_end = qend && (q == 2'd3);
    assign sample   = qend && (q == 2'd2);
    assign active   = (state != IDLE) && (state != DONE);
    assign multi    = (state == ADDR) || (state == RD_MSB) || (state == RD_LSB);
    assign last_bit = slot_end && (bcnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)    state_nxt = START;
            START:    if (slot_end) state_nxt = ADDR;
            ADDR:     if (last_bit) state_nxt = ADDR_ACK;
            ADDR_ACK: if (slot_end) state_nxt = ack_samp ? STOP : RD_MSB;
            RD_MSB:   if (last_bit) state_nxt = ACK_MSB;
            ACK_MSB:  if (slot_end) state_nxt = RD_LSB;
            RD_LSB:   if (last_bit) state_nxt = NACK_LSB;
            NACK_LSB: if (slot_end) state_nxt = STOP;
            STOP:     if (slot_end) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // START and STOP move SDA while SCL is high; every other state only touches SDA at Q0
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        busy   = (state != IDLE);
        case (state)
            START:    sda_oe = q[1];
            ADDR: begin
                scl    = q[1];
                sda_oe = ~addr_bit(bcnt);
            end
            ADDR_ACK, RD_MSB, RD_LSB, NACK_LSB: scl = q[1];
            ACK_MSB: begin
                scl    = q[1];
                sda_oe = 1'b1;
            end
            STOP: begin
                scl    = q[1];
                sda_oe = (q != 2'd3);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt <= '0;
            q    <= 2'd0;
            bcnt <= 3'd0;
        end else if (!active) begin
            qcnt <= '0;
            q    <= 2'd0;
            bcnt <= 3'd0;
        end else if (qend) begin
            qcnt <= '0;
            q    <= q + 2'd1;
            if ((q == 2'd3) && multi) bcnt <= bcnt + 3'd1;
        end else begin
            qcnt <= qcnt + QONE;
        end
    end

    // Shift register and ACK sample carry no reset; they are always rewritten before use
    always_ff @(posedge clk) begin
        if (sample) begin
            if (state == ADDR_ACK) ack_samp <= sda_in;
            if ((state == RD_MSB) || (state == RD_LSB)) sreg <= {sreg[14:0], sda_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= 16'h0000;
            valid    <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            valid <= (state == DONE) && !nack_err;
            if ((state == DONE) && !nack_err) data <= sreg;
            if ((state == IDLE) && start)
                nack_err <= 1'b0;
            else if ((state == ADDR_ACK) && slot_end && ack_samp)
                nack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lm75_i2c_reader.sv
// Bench for lm75_i2c_reader: bus-level sensor model, protocol monitor and directed/random reads.
module tb_lm75_i2c_reader;

    localparam int Q    = 4;
    localparam int LAT  = 1 + 29 * 4 * Q;
    localparam int NLAT = 1 + 11 * 4 * Q;

    logic        clk, rst, start, sda_in, scl, sda_oe, valid, busy, nack_err;
    logic [15:0] data;
    logic        pull;
    logic        sda_bus;

    int checks = 0;
    int errors = 0;

    // sensor model state
    bit          sens_present;
    logic [7:0]  sens_msb, sens_lsb;
    bit          acked;
    int          fall_cnt;
    logic        rx [0:31];
    int          starts, stops, vcount;
    logic        prev_scl, prev_sda;
    logic [15:0] exp_data;

    assign sda_bus = ~(sda_oe | pull);
    assign sda_in  = sda_bus;

    lm75_i2c_reader #(.QUARTER_CLKS(Q), .DEV_ADDR(7'h48)) dut (
        .clk(clk), .rst(rst), .start(start), .sda_in(sda_in),
        .scl(scl), .sda_oe(sda_oe), .data(data), .valid(valid),
        .busy(busy), .nack_err(nack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sensor and protocol monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (valid) vcount++;
        if (rst) begin
            pull     = 1'b0;
            fall_cnt = 0;
            acked    = 1'b0;
            prev_scl = scl;
            prev_sda = sda_bus;
        end else begin
            logic cs, cd;
            int   slot;
            cs = scl;
            cd = sda_bus;
            if (prev_scl && cs && prev_sda && !cd) begin
                starts++;
                fall_cnt = 0;
                acked    = 1'b0;
                pull     = 1'b0;
            end else if (prev_scl && cs && !prev_sda && cd) begin
                stops++;
            end
            if (prev_scl && !cs) begin
                slot = fall_cnt;
                fall_cnt++;
                if (slot == 8) begin
                    acked = sens_present &&
                            ({rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7]} == 8'h91);
                    pull = acked;
                end else if (slot >= 9 && slot <= 16)
                    pull = acked && !sens_msb[16 - slot];
                else if (slot >= 18 && slot <= 25)
                    pull = acked && !sens_lsb[25 - slot];
                else
                    pull = 1'b0;
            end
            if (!prev_scl && cs && fall_cnt >= 1 && fall_cnt <= 32)
                rx[fall_cnt - 1] = cd;
            prev_scl = cs;
            prev_sda = cd;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic run_txn(input bit pres, input logic [7:0] m, input logic [7:0] l,
                           input int extra, input int rst_at, input string tag);
        int         cyc;
        int         lat;
        logic [7:0] abyte;
        sens_present = pres;
        sens_msb     = m;
        sens_lsb     = l;
        @(negedge clk);
        starts = 0;
        stops  = 0;
        vcount = 0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        lat   = -1;
        check({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        check({tag, "_nack_clr"}, {31'd0, nack_err}, 32'd0);
        while (busy && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (valid && lat < 0) lat = cyc;
            if (cyc == extra) start = 1'b1;
            if (rst_at > 0 && cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_scl"}, {31'd0, scl}, 32'd1);
                check({tag, "_rst_sdaoe"}, {31'd0, sda_oe}, 32'd0);
                check({tag, "_rst_data"}, {16'd0, data}, 32'd0);
                check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_rst_valid"}, {31'd0, valid}, 32'd0);
                check({tag, "_rst_nack"}, {31'd0, nack_err}, 32'd0);
                repeat (2) @(negedge clk);
                rst      = 1'b0;
                exp_data = 16'h0000;
                repeat (4) @(negedge clk);
                check({tag, "_rst_vcnt"}, vcount, 0);
                return;
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) abyte[7 - k] = rx[k];
        check({tag, "_addr"}, {24'd0, abyte}, 32'h91);
        if (pres) begin
            exp_data = {m, l};
            check({tag, "_latency"}, lat, LAT);
            check({tag, "_slave_ack"}, {31'd0, rx[8]}, 32'd0);
            check({tag, "_master_ack"}, {31'd0, rx[17]}, 32'd0);
            check({tag, "_master_nack"}, {31'd0, rx[26]}, 32'd1);
            check({tag, "_nack_err"}, {31'd0, nack_err}, 32'd0);
        end else begin
            check({tag, "_nack_len"}, cyc, NLAT);
            check({tag, "_nack_err"}, {31'd0, nack_err}, 32'd1);
        end
        check({tag, "_data"}, {16'd0, data}, {16'd0, exp_data});
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_vcnt"}, vcount, pres ? 1 : 0);
        check({tag, "_starts"}, starts, 1);
        check({tag, "_stops"}, stops, 1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        pull         = 1'b0;
        sens_present = 1'b0;
        sens_msb     = 8'h00;
        sens_lsb     = 8'h00;
        starts       = 0;
        stops        = 0;
        vcount       = 0;
        fall_cnt     = 0;
        exp_data     = 16'h0000;
        for (int k = 0; k < 32; k++) rx[k] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_scl", {31'd0, scl}, 32'd1);
        check("reset_sdaoe", {31'd0, sda_oe}, 32'd0);
        check("reset_data", {16'd0, data}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_nack", {31'd0, nack_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_txn(1'b1, 8'h19, 8'h80, -1, 0, "t1980");
        run_txn(1'b0, 8'h55, 8'hAA, -1, 0, "absent");
        run_txn(1'b1, 8'hE7, 8'h00, -1, 0, "tE700");
        check("neg_sign", {31'd0, data[15]}, 32'd1);
        run_txn(1'b1, 8'h21, 8'h00, 1 + 16 * 13 + 8, 0, "midstart");
        run_txn(1'b1, 8'h33, 8'h80, LAT - 1, 0, "donestart");
        run_txn(1'b1, 8'h3C, 8'h80, -1, 1 + 16 * 22, "rstlsb");
        check("post_rst_data", {16'd0, data}, 32'd0);
        run_txn(1'b1, 8'h0A, 8'h80, -1, 0, "afterrst");

        for (int i = 0; i < 4; i++) begin
            bit         p;
            logic [7:0] rm, rl;
            p  = ($urandom_range(0, 3) != 0);
            rm = 8'($urandom);
            rl = 8'($urandom);
            run_txn(p, rm, rl, -1, 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
